// File: rtl/uart_cmd_framer.sv
// UART byte-stream framer: HEADER + NBYTES payload + additive checksum,
// inter-byte timeout, and a held valid/ready command output.
module uart_cmd_framer #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         NBYTES      = 6,
  parameter int         TIMEOUT_CYC = 43000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        rx_en,
  output logic [47:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        err_chk,
  output logic        err_tmo,
  output logic        err_ovf,
  output logic [7:0]  frame_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0] IDX_LAST = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHK,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [47:0]   shadow_q, shadow_d;
  logic [47:0]   cmd_data_q, cmd_data_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          err_chk_q, err_chk_d;
  logic          err_tmo_q, err_tmo_d;
  logic          err_ovf_q, err_ovf_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          in_frame;
  logic          expire;

  assign in_frame = (state_q == PAYLOAD) || (state_q == CHK);
  // An arriving byte always beats a simultaneous expiry.
  assign expire   = in_frame && !rx_done && (tmr_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    shadow_d    = shadow_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    frame_cnt_d = frame_cnt_q;
    err_chk_d   = 1'b0;
    err_tmo_d   = 1'b0;
    err_ovf_d   = 1'b0;
    tmr_d       = '0;
    if (in_frame && !rx_done) begin
      tmr_d = tmr_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (rx_done && (rx_data == HEADER)) begin
          state_d  = PAYLOAD;
          idx_d    = '0;
          sum_d    = '0;
          shadow_d = '0;
        end
      end
      PAYLOAD: begin
        if (rx_done) begin
          shadow_d = {shadow_q[39:0], rx_data};
          sum_d    = sum_q + rx_data;
          idx_d    = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
            state_d = CHK;
          end
        end else if (expire) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end
      end
      CHK: begin
        if (rx_done) begin
          if (rx_data == sum_q) begin
            state_d     = HOLD;
            cmd_valid_d = 1'b1;
            cmd_data_d  = shadow_q;
          end else begin
            err_chk_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (expire) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end
      end
      HOLD: begin
        err_ovf_d = rx_done;
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      tmr_q       <= '0;
      shadow_q    <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      err_chk_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmr_q       <= tmr_d;
      shadow_q    <= shadow_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      err_chk_q   <= err_chk_d;
      err_tmo_q   <= err_tmo_d;
      err_ovf_q   <= err_ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rx_en     = (state_q != HOLD);
  assign cmd_data  = cmd_data_q;
  assign cmd_valid = cmd_valid_q;
  assign err_chk   = err_chk_q;
  assign err_tmo   = err_tmo_q;
  assign err_ovf   = err_ovf_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: good/bad frames, timeout,
// HOLD overflow, noise rejection and mid-frame reset.
module tb_uart_cmd_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        rx_en;
  logic [47:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        err_chk;
  logic        err_tmo;
  logic        err_ovf;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;
  int n_chk = 0;
  int n_tmo = 0;
  int n_ovf = 0;
  int n_val = 0;
  int found;

  uart_cmd_framer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_en     (rx_en),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .err_chk   (err_chk),
    .err_tmo   (err_tmo),
    .err_ovf   (err_ovf),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (err_chk) n_chk++;
    if (err_tmo) n_tmo++;
    if (err_ovf) n_ovf++;
    if (cmd_valid) n_val++;
  end

  task automatic check(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    repeat (2) @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_pl(input logic [47:0] pl, input logic [7:0] c);
    send(8'hAA);
    for (int i = 5; i >= 0; i--) send(pl[8*i +: 8]);
    send(c);
  endtask

  initial begin
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_data", cmd_data, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_rxen", rx_en, 1);
    check("rst_errs", {err_chk, err_tmo, err_ovf}, 0);
    rst_n = 1'b1;

    // good frame, consumer ready
    send_pl(48'h010203040506, 8'h15);
    check("t1_valid", cmd_valid, 1);
    check("t1_data", cmd_data, 48'h010203040506);
    check("t1_rxen", rx_en, 0);
    @(negedge clk);
    check("t1_valid_drop", cmd_valid, 0);
    check("t1_cnt", frame_cnt, 1);
    check("t1_rxen_back", rx_en, 1);
    check("t1_vcycles", n_val, 1);

    // bad checksum then recovery
    send_pl(48'h010203040506, 8'h16);
    check("t2_errchk", err_chk, 1);
    check("t2_novalid", cmd_valid, 0);
    @(negedge clk);
    check("t2_errchk_1cyc", err_chk, 0);
    send_pl(48'h010203040506, 8'h15);
    check("t2_valid", cmd_valid, 1);
    @(negedge clk);
    check("t2_cnt", frame_cnt, 2);
    check("t2_nchk", n_chk, 1);

    // inter-byte timeout
    send(8'hAA);
    send(8'h11);
    send(8'h22);
    repeat (42990) @(negedge clk);
    check("t3_no_early_tmo", n_tmo, 0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (err_tmo) found = 1;
    end
    check("t3_tmo_seen", found, 1);
    repeat (3) @(negedge clk);
    check("t3_tmo_width", n_tmo, 1);
    check("t3_novalid", cmd_valid, 0);
    send_pl(48'h112233445566, 8'h65);
    check("t3_valid", cmd_valid, 1);
    check("t3_data", cmd_data, 48'h112233445566);
    @(negedge clk);
    check("t3_cnt", frame_cnt, 3);

    // HOLD with back-pressure and overflow bytes
    cmd_ready = 1'b0;
    send_pl(48'h102030405060, 8'h50);
    check("t4_valid", cmd_valid, 1);
    check("t4_rxen", rx_en, 0);
    send(8'h55);
    check("t4_ovf", err_ovf, 1);
    repeat (100) @(negedge clk);
    check("t4_hold_valid", cmd_valid, 1);
    check("t4_hold_data", cmd_data, 48'h102030405060);
    check("t4_hold_rxen", rx_en, 0);
    check("t4_hold_cnt", frame_cnt, 3);
    check("t4_novf", n_ovf, 1);
    cmd_ready = 1'b1;
    rx_data = 8'hAA;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    check("t4_sim_valid", cmd_valid, 0);
    check("t4_sim_ovf", err_ovf, 1);
    check("t4_sim_cnt", frame_cnt, 4);
    check("t4_sim_rxen", rx_en, 1);
    for (int i = 1; i <= 6; i++) send(8'(i));
    send(8'h15);
    repeat (3) @(negedge clk);
    check("t4_hdr_not_parsed", cmd_valid, 0);
    check("t4_cnt_after", frame_cnt, 4);
    check("t4_novf2", n_ovf, 2);

    // noise then checksum wrap
    send(8'h00);
    send(8'hFF);
    send(8'h13);
    send_pl(48'hFFFFFFFFFFFF, 8'hFA);
    check("t5_valid", cmd_valid, 1);
    check("t5_data", cmd_data, 48'hFFFFFFFFFFFF);
    @(negedge clk);
    check("t5_cnt", frame_cnt, 5);

    // reset mid-frame
    send(8'hAA);
    send(8'h01);
    send(8'h02);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data", cmd_data, 0);
    check("t6_rst_valid", cmd_valid, 0);
    check("t6_rst_cnt", frame_cnt, 0);
    check("t6_rst_rxen", rx_en, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_pl(48'h0A0B0C0D0E0F, 8'h4B);
    check("t6_valid", cmd_valid, 1);
    check("t6_data", cmd_data, 48'h0A0B0C0D0E0F);
    @(negedge clk);
    check("t6_cnt", frame_cnt, 1);
    check("end_nchk", n_chk, 1);
    check("end_ntmo", n_tmo, 1);
    check("end_novf", n_ovf, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
